// File: rtl/draw_sprite_multi_pkg.sv
// Shared types and defaults for the multi-sprite overlay: latched per-channel
// attribute record, VGA timing bundle and the saturating tint helper.
package draw_sprite_multi_pkg;

  localparam int          SPR_W_DEF     = 48;
  localparam int          SPR_H_DEF     = 64;
  localparam int          N_FRAMES_DEF  = 4;
  localparam logic [11:0] KEY_COLOR_DEF = 12'hFAC;
  localparam logic [11:0] TINT_DEF      = 12'h4D2;

  // Latched frame index is held at a fixed width; wider FRAME_W is truncated.
  localparam int FRAME_MAX_W = 8;

  typedef struct packed {
    logic [11:0]            x;
    logic [11:0]            y;
    logic [1:0]             level;
    logic                   en;
    logic                   mirror;
    logic [FRAME_MAX_W-1:0] frame;
  } char_attr_t;

  typedef struct packed {
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_sig_t;

  function automatic logic [11:0] tint_add(input logic [11:0] pix, input logic [11:0] tint);
    logic [4:0]  sum;
    logic [11:0] res;
    res = '0;
    for (int k = 0; k < 3; k++) begin
      sum = {1'b0, pix[4*k +: 4]} + {1'b0, tint[4*k +: 4]};
      res[4*k +: 4] = sum[4] ? 4'hF : sum[3:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/draw_sprite_multi_if.sv
// VGA stream bundle: timing counters, sync/blank flags and 12-bit rgb.
interface draw_sprite_multi_if;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_sprite_multi_sprite_hit_addr.sv
// One sprite channel: registered hit flag and sprite ROM address for the
// current pixel, computed from the attributes latched at vblank.
module draw_sprite_multi_sprite_hit_addr
  import draw_sprite_multi_pkg::*;
#(
  parameter int SPR_W  = SPR_W_DEF,
  parameter int SPR_H  = SPR_H_DEF,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  char_attr_t        i_attr,
  input  logic [1:0]        i_level_view,
  input  logic [11:0]       i_hcount,
  input  logic [11:0]       i_vcount,
  input  logic              i_active,
  output logic              o_hit,
  output logic [ADDR_W-1:0] o_addr
);

  localparam logic [12:0]       W13      = 13'(SPR_W);
  localparam logic [12:0]       H13      = 13'(SPR_H);
  localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(SPR_W * SPR_H);
  localparam logic [ADDR_W-1:0] ROW_SZ   = ADDR_W'(SPR_W);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(SPR_W - 1);

  logic [12:0]       w_h13, w_v13, w_x13, w_y13;
  logic [12:0]       w_dx13, w_dy13;
  logic              w_in_x, w_in_y, w_hit;
  logic [ADDR_W-1:0] w_dx, w_dy, w_dx_eff, w_addr;
  logic              r_hit;
  logic [ADDR_W-1:0] r_addr;

  // 13-bit compares so a sprite near column 4095 clips instead of wrapping
  assign w_h13 = {1'b0, i_hcount};
  assign w_v13 = {1'b0, i_vcount};
  assign w_x13 = {1'b0, i_attr.x};
  assign w_y13 = {1'b0, i_attr.y};

  assign w_in_x = (w_h13 >= w_x13) && (w_h13 < (w_x13 + W13));
  assign w_in_y = (w_v13 >= w_y13) && (w_v13 < (w_y13 + H13));
  assign w_hit  = i_active && i_attr.en && (i_attr.level == i_level_view) && w_in_x && w_in_y;

  assign w_dx13   = w_h13 - w_x13;
  assign w_dy13   = w_v13 - w_y13;
  assign w_dx     = ADDR_W'(w_dx13);
  assign w_dy     = ADDR_W'(w_dy13);
  assign w_dx_eff = i_attr.mirror ? (COL_LAST - w_dx) : w_dx;
  assign w_addr   = (ADDR_W'(i_attr.frame) * FRAME_SZ) + (w_dy * ROW_SZ) + w_dx_eff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit  <= 1'b0;
      r_addr <= '0;
    end else begin
      r_hit  <= w_hit;
      r_addr <= w_hit ? w_addr : '0;
    end
  end

  assign o_hit  = r_hit;
  assign o_addr = r_addr;

endmodule

// File: rtl/draw_sprite_multi.sv
// Multi-channel sprite compositor for the VGA chain (latency ROM_LAT+2).
// Define DRAW_SPRITE_TINT_EN to tint channels >= 1 by TINT (saturating).
module draw_sprite_multi
  import draw_sprite_multi_pkg::*;
#(
  parameter int          N_CHAR    = 2,
  parameter int          SPR_W     = SPR_W_DEF,
  parameter int          SPR_H     = SPR_H_DEF,
  parameter int          N_FRAMES  = N_FRAMES_DEF,
  parameter int          ROM_LAT   = 1,
  parameter logic [11:0] KEY_COLOR = KEY_COLOR_DEF,
  parameter logic [11:0] TINT      = TINT_DEF,
  localparam int         FRAME_W   = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1,
  localparam int         ADDR_W    = $clog2(N_FRAMES * SPR_W * SPR_H),
  localparam int         LAT       = ROM_LAT + 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  draw_sprite_multi_if.slave              vga_in,
  draw_sprite_multi_if.master             vga_out,
  input  logic [N_CHAR-1:0][11:0]         char_x,
  input  logic [N_CHAR-1:0][11:0]         char_y,
  input  logic [N_CHAR-1:0][1:0]          char_level,
  input  logic [N_CHAR-1:0]               char_en,
  input  logic [N_CHAR-1:0]               char_mirror,
  input  logic [N_CHAR-1:0][FRAME_W-1:0]  char_frame,
  input  logic [1:0]                      level_view,
  output logic [N_CHAR-1:0][ADDR_W-1:0]   pixel_addr,
  input  logic [N_CHAR-1:0][11:0]         rgb_pixel
);

`ifdef DRAW_SPRITE_TINT_EN
  localparam logic TINT_ON = 1'b1;
`else
  localparam logic TINT_ON = 1'b0;
`endif
  // With the tint disabled the added amount is zero, so raw pixels pass.
  localparam logic [11:0] TINT_EFF = TINT & {12{TINT_ON}};

  char_attr_t        r_attr [N_CHAR];
  char_attr_t        w_attr_new [N_CHAR];
  logic [1:0]        r_level_view;
  logic              r_vblnk_prev;
  logic              w_latch;
  logic              w_active;
  logic [N_CHAR-1:0] w_hit;
  logic [N_CHAR-1:0] r_hit_d [ROM_LAT];
  logic [N_CHAR-1:0] w_hit_al;
  vga_sig_t          w_in;
  vga_sig_t          r_pipe [LAT-1];
  vga_sig_t          w_dly;
  vga_sig_t          r_out;
  logic [11:0]       w_rgb_next;

  assign w_latch  = vga_in.vblnk & ~r_vblnk_prev;
  assign w_active = ~vga_in.hblnk & ~vga_in.vblnk;

  always_comb begin
    for (int i = 0; i < N_CHAR; i++) begin
      w_attr_new[i]        = '0;
      w_attr_new[i].x      = char_x[i];
      w_attr_new[i].y      = char_y[i];
      w_attr_new[i].level  = char_level[i];
      w_attr_new[i].en     = char_en[i];
      w_attr_new[i].mirror = char_mirror[i];
      w_attr_new[i].frame  = (int'(char_frame[i]) >= N_FRAMES) ?
                             FRAME_MAX_W'(N_FRAMES - 1) : FRAME_MAX_W'(char_frame[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vblnk_prev <= 1'b0;
      r_level_view <= '0;
      for (int i = 0; i < N_CHAR; i++) r_attr[i] <= '0;
    end else begin
      r_vblnk_prev <= vga_in.vblnk;
      if (w_latch) begin
        r_level_view <= level_view;
        for (int i = 0; i < N_CHAR; i++) r_attr[i] <= w_attr_new[i];
      end
    end
  end

  for (genvar g = 0; g < N_CHAR; g++) begin : g_chan
    draw_sprite_multi_sprite_hit_addr #(
      .SPR_W  (SPR_W),
      .SPR_H  (SPR_H),
      .ADDR_W (ADDR_W)
    ) u_hit_addr (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_attr       (r_attr[g]),
      .i_level_view (r_level_view),
      .i_hcount     (vga_in.hcount),
      .i_vcount     (vga_in.vcount),
      .i_active     (w_active),
      .o_hit        (w_hit[g]),
      .o_addr       (pixel_addr[g])
    );
  end

  always_comb begin
    w_in        = '0;
    w_in.hcount = vga_in.hcount;
    w_in.vcount = vga_in.vcount;
    w_in.hsync  = vga_in.hsync;
    w_in.vsync  = vga_in.vsync;
    w_in.hblnk  = vga_in.hblnk;
    w_in.vblnk  = vga_in.vblnk;
    w_in.rgb    = vga_in.rgb;
  end

  // Timing/background run LAT-1 stages; the output register adds the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT-1; k++) r_pipe[k] <= '0;
      for (int k = 0; k < ROM_LAT; k++) r_hit_d[k] <= '0;
    end else begin
      r_pipe[0] <= w_in;
      for (int k = 1; k < LAT-1; k++) r_pipe[k] <= r_pipe[k-1];
      r_hit_d[0] <= w_hit;
      for (int k = 1; k < ROM_LAT; k++) r_hit_d[k] <= r_hit_d[k-1];
    end
  end

  assign w_dly    = r_pipe[LAT-2];
  assign w_hit_al = r_hit_d[ROM_LAT-1];

  // Scan from lowest priority upward so channel 0 overrides last.
  always_comb begin
    w_rgb_next = w_dly.rgb;
    for (int i = N_CHAR-1; i >= 0; i--) begin
      if (w_hit_al[i] && (rgb_pixel[i] != KEY_COLOR)) begin
        w_rgb_next = (i >= 1) ? tint_add(rgb_pixel[i], TINT_EFF) : rgb_pixel[i];
      end
    end
    if (w_dly.hblnk || w_dly.vblnk) w_rgb_next = w_dly.rgb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else begin
      r_out     <= w_dly;
      r_out.rgb <= w_rgb_next;
    end
  end

  assign vga_out.hcount = r_out.hcount;
  assign vga_out.vcount = r_out.vcount;
  assign vga_out.hsync  = r_out.hsync;
  assign vga_out.vsync  = r_out.vsync;
  assign vga_out.hblnk  = r_out.hblnk;
  assign vga_out.vblnk  = r_out.vblnk;
  assign vga_out.rgb    = r_out.rgb;

endmodule

// File: tb/tb_draw_sprite_multi.sv
// Directed + randomized bench for draw_sprite_multi against an arithmetic
// reference model of sprite placement, priority, keying and latching.
module tb_draw_sprite_multi;
  import draw_sprite_multi_pkg::*;

  localparam int N   = 2;
  localparam int W   = 48;
  localparam int H   = 64;
  localparam int NF  = 3;
  localparam int RL  = 1;
  localparam int LAT = RL + 2;
  localparam int FW  = 2;
  localparam int AW  = $clog2(NF * W * H);
  localparam logic [11:0] KEY = 12'hFAC;
`ifdef DRAW_SPRITE_TINT_EN
  localparam logic [11:0] TNT     = 12'h4D2;
  localparam logic [11:0] CH1_GRN = 12'h4F2;
  localparam logic [11:0] CH1_C21 = 12'hFF3;
`else
  localparam logic [11:0] CH1_GRN = 12'h0F0;
  localparam logic [11:0] CH1_C21 = 12'hC21;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  draw_sprite_multi_if vin ();
  draw_sprite_multi_if vout ();
  logic [N-1:0][11:0]   char_x, char_y;
  logic [N-1:0][1:0]    char_level;
  logic [N-1:0]         char_en, char_mirror;
  logic [N-1:0][FW-1:0] char_frame;
  logic [1:0]           level_view;
  logic [N-1:0][AW-1:0] pixel_addr;
  logic [N-1:0][11:0]   rgb_pixel;

  draw_sprite_multi #(.N_CHAR(N), .N_FRAMES(NF), .ROM_LAT(RL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vga_in      (vin),
    .vga_out     (vout),
    .char_x      (char_x),
    .char_y      (char_y),
    .char_level  (char_level),
    .char_en     (char_en),
    .char_mirror (char_mirror),
    .char_frame  (char_frame),
    .level_view  (level_view),
    .pixel_addr  (pixel_addr),
    .rgb_pixel   (rgb_pixel)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Sprite ROM model: constant per channel, or an address hash with key holes.
  int          rom_mode = 0;
  logic [11:0] rom_const [N];

  function automatic logic [11:0] rom(input int c, input int a);
    if (rom_mode == 0) return rom_const[c];
    if (((a + 3 * c) % 7) == 0) return KEY;
    return 12'((a * 37 + c * 1111 + 5) % 4096);
  endfunction

  always @(posedge clk)
    for (int c = 0; c < N; c++) rgb_pixel[c] <= rom(c, int'(pixel_addr[c]));

  function automatic logic [11:0] model_tint(input logic [11:0] p);
`ifdef DRAW_SPRITE_TINT_EN
    logic [11:0] t;
    logic [11:0] r;
    int s;
    t = TNT;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      s = int'(p[4*k +: 4]) + int'(t[4*k +: 4]);
      r[4*k +: 4] = (s > 15) ? 4'hF : 4'(s);
    end
    return r;
`else
    return p;
`endif
  endfunction

  // Reference model state: attributes as seen by the current frame.
  int m_x [N], m_y [N], m_lvl [N], m_en [N], m_mir [N], m_frm [N];
  int m_view, m_prev_vb;
  int exp_addr [N];

  typedef struct packed {
    logic [11:0] rgb;
    logic [27:0] tim;
  } exp_t;
  exp_t q[$];

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_x[c] = 0; m_y[c] = 0; m_lvl[c] = 0; m_en[c] = 0; m_mir[c] = 0; m_frm[c] = 0;
    end
    m_view = 0;
    m_prev_vb = 0;
    q.delete();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic step(input int h_in, input int v_in, input logic hb, input logic vb,
                      input logic [11:0] bg);
    int h, v, dx, f;
    logic hs, vs, found;
    logic [11:0] px;
    exp_t e;
    h = h_in & 4095;
    v = v_in & 4095;
    hs = 1'($urandom % 2);
    vs = 1'($urandom % 2);
    vin.hcount = 12'(h);
    vin.vcount = 12'(v);
    vin.hsync  = hs;
    vin.vsync  = vs;
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.rgb    = bg;
    e.rgb = bg;
    e.tim = {12'(h), 12'(v), hs, vs, hb, vb};
    found = 1'b0;
    for (int c = 0; c < N; c++) begin
      exp_addr[c] = 0;
      if (!hb && !vb && m_en[c] == 1 && m_lvl[c] == m_view &&
          h >= m_x[c] && h < m_x[c] + W && v >= m_y[c] && v < m_y[c] + H) begin
        dx = h - m_x[c];
        if (m_mir[c] == 1) dx = W - 1 - dx;
        exp_addr[c] = m_frm[c] * W * H + (v - m_y[c]) * W + dx;
        if (!found) begin
          px = rom(c, exp_addr[c]);
          if (px != KEY) begin
            found = 1'b1;
            e.rgb = (c >= 1) ? model_tint(px) : px;
          end
        end
      end
    end
    if (vb && m_prev_vb == 0) begin
      for (int c = 0; c < N; c++) begin
        m_x[c] = int'(char_x[c]);
        m_y[c] = int'(char_y[c]);
        m_lvl[c] = int'(char_level[c]);
        m_en[c] = int'(char_en[c]);
        m_mir[c] = int'(char_mirror[c]);
        f = int'(char_frame[c]);
        m_frm[c] = (f > NF - 1) ? NF - 1 : f;
      end
      m_view = int'(level_view);
    end
    m_prev_vb = int'(vb);
    q.push_back(e);
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) chk("pixel_addr", 32'(pixel_addr[c]), 32'(exp_addr[c]));
    if (q.size() == LAT) begin
      e = q.pop_front();
      chk("rgb", 32'(vout.rgb), 32'(e.rgb));
      chk("timing", 32'({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}),
          32'(e.tim));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1'b1, 1'b0, 12'($urandom));
  endtask

  task automatic vpulse();
    step(0, 0, 1'b0, 1'b1, 12'h000);
    step(0, 0, 1'b1, 1'b0, 12'h000);
  endtask

  task automatic set_ch(input int c, input int x, input int y, input int lvl, input int en,
                        input int mir, input int frm);
    char_x[c] = 12'(x);
    char_y[c] = 12'(y);
    char_level[c] = 2'(lvl);
    char_en[c] = 1'(en);
    char_mirror[c] = 1'(mir);
    char_frame[c] = FW'(frm);
  endtask

  task automatic chk_reset_zero();
    chk("rst_rgb", 32'(vout.rgb), 32'h0);
    chk("rst_timing", 32'({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}),
        32'h0);
    for (int c = 0; c < N; c++) chk("rst_addr", 32'(pixel_addr[c]), 32'h0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rom_const[0] = 12'h123;
    rom_const[1] = 12'h0F0;
    for (int i = 0; i < N; i++) set_ch(i, 0, 0, 0, 0, 0, 0);
    level_view = 2'd1;
    vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
    vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;
    model_reset();

    #1 rst_n = 1'b0;
    #2 chk_reset_zero();
    rst_n = 1'b1;

    // nothing drawn before the first vblank latch
    set_ch(0, 100, 50, 1, 1, 0, 0);
    step(100, 50, 1'b0, 1'b0, 12'h555);
    idle(2);
    chk("no_latch_bg", 32'(vout.rgb), 32'h555);

    vpulse();
    step(100, 50, 1'b0, 1'b0, 12'h555);
    chk("addr_origin", 32'(pixel_addr[0]), 32'd0);
    idle(2);
    chk("sprite_rgb", 32'(vout.rgb), 32'h123);
    step(147, 113, 1'b0, 1'b0, 12'h555);
    chk("addr_far_corner", 32'(pixel_addr[0]), 32'd3071);
    step(99, 50, 1'b0, 1'b0, 12'h321);
    step(148, 50, 1'b0, 1'b0, 12'h321);
    step(100, 49, 1'b0, 1'b0, 12'h321);
    step(100, 114, 1'b0, 1'b0, 12'h321);
    step(120, 60, 1'b1, 1'b0, 12'h321);
    idle(2);

    set_ch(0, 100, 50, 1, 1, 1, 0);
    vpulse();
    step(100, 50, 1'b0, 1'b0, 12'h555);
    chk("addr_mirror", 32'(pixel_addr[0]), 32'd47);
    step(147, 50, 1'b0, 1'b0, 12'h555);
    set_ch(0, 100, 50, 1, 1, 0, 2);
    vpulse();
    step(100, 50, 1'b0, 1'b0, 12'h555);
    chk("addr_frame2", 32'(pixel_addr[0]), 32'd6144);
    set_ch(0, 100, 50, 1, 1, 0, 3);
    vpulse();
    step(100, 50, 1'b0, 1'b0, 12'h555);
    chk("addr_frame_clamp", 32'(pixel_addr[0]), 32'd6144);

    // overlap: keyed ch0 falls through, then ch0 wins, then level gate
    set_ch(0, 100, 50, 1, 1, 0, 0);
    set_ch(1, 100, 50, 1, 1, 0, 0);
    vpulse();
    idle(2);
    rom_const[0] = KEY;
    step(110, 60, 1'b0, 1'b0, 12'h555);
    idle(2);
    chk("key_fallthrough", 32'(vout.rgb), 32'(CH1_GRN));
    rom_const[0] = 12'h123;
    step(110, 60, 1'b0, 1'b0, 12'h555);
    idle(2);
    chk("ch0_priority", 32'(vout.rgb), 32'h123);
    set_ch(0, 100, 50, 2, 1, 0, 0);
    vpulse();
    step(110, 60, 1'b0, 1'b0, 12'h555);
    idle(2);
    chk("level_gate", 32'(vout.rgb), 32'(CH1_GRN));
    rom_const[1] = 12'hC21;
    step(110, 60, 1'b0, 1'b0, 12'h555);
    idle(2);
    chk("ch1_pixel", 32'(vout.rgb), 32'(CH1_C21));
    rom_const[1] = 12'h0F0;

    // mid-frame position change takes effect only at next vblank
    set_ch(1, 0, 0, 0, 0, 0, 0);
    set_ch(0, 100, 280, 1, 1, 0, 0);
    vpulse();
    step(110, 300, 1'b0, 1'b0, 12'h555);
    char_x[0] = 12'd200;
    step(110, 300, 1'b0, 1'b0, 12'h555);
    chk("midframe_old_pos", 32'(pixel_addr[0]), 32'd970);
    step(210, 300, 1'b0, 1'b0, 12'h555);
    chk("midframe_new_pos", 32'(pixel_addr[0]), 32'd0);
    vpulse();
    step(210, 300, 1'b0, 1'b0, 12'h555);
    chk("nextframe_new_pos", 32'(pixel_addr[0]), 32'd970);
    step(110, 300, 1'b0, 1'b0, 12'h555);
    step(212, 301, 1'b0, 1'b0, 12'h555);

    // reset mid-line clears everything immediately
    rst_n = 1'b0;
    #2 chk_reset_zero();
    rst_n = 1'b1;
    model_reset();
    step(210, 300, 1'b0, 1'b0, 12'h555);
    chk("post_rst_no_sprite", 32'(pixel_addr[0]), 32'd0);
    idle(2);
    chk("post_rst_bg", 32'(vout.rgb), 32'h555);
    vpulse();
    step(210, 300, 1'b0, 1'b0, 12'h555);
    chk("post_rst_latch", 32'(pixel_addr[0]), 32'd970);
    idle(3);

    // randomized frames; attributes change mid-frame and latch at the pulse
    rom_mode = 1;
    for (int fr = 0; fr < 12; fr++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom % 4 == 0) char_x[i] = 12'(4040 + $urandom_range(0, 55));
        else                   char_x[i] = 12'($urandom_range(0, 300));
        if ($urandom % 5 == 0) char_y[i] = 12'(4030 + $urandom_range(0, 65));
        else                   char_y[i] = 12'($urandom_range(0, 200));
        char_level[i]  = 2'($urandom % 2);
        char_en[i]     = 1'($urandom % 4 != 0);
        char_mirror[i] = 1'($urandom % 2);
        char_frame[i]  = FW'($urandom % 4);
      end
      if ($urandom % 3 == 0) begin
        char_x[1] = char_x[0];
        char_y[1] = char_y[0];
      end
      level_view = 2'($urandom % 2);
      vpulse();
      for (int s = 0; s < 160; s++) begin
        if (s == 80) begin
          char_x[0] = 12'($urandom);
          char_en[1] = ~char_en[1];
          level_view = ~level_view;
        end
        c = int'($urandom % N);
        step(m_x[c] + int'($urandom_range(0, W + 10)) - 5,
             m_y[c] + int'($urandom_range(0, H + 10)) - 5,
             1'($urandom % 12 == 0), 1'b0, 12'($urandom));
      end
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
